// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_pkg
// Purpose : Shared types and default widths for the common data bus (CDB).
//           cdb_pkt_t is one broadcast payload: rename tag, result data and
//           ROB index. It is used both for the per-EXU input view and for the
//           registered broadcast.
// Revision: 1.0 - initial release
// ============================================================================
package cdb_pkg;

  localparam int CDB_TAG_W     = 4;
  localparam int CDB_ROB_DEPTH = 16;
  localparam int CDB_ROB_PTR_W = $clog2(CDB_ROB_DEPTH);
  localparam int CDB_DATA_W    = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]     tag;
    logic [CDB_DATA_W-1:0]    wdata;
    logic [CDB_ROB_PTR_W-1:0] inst_id;
  } cdb_pkt_t;

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational rotating-priority arbiter. Scans ptr, ptr+1, ...
//           modulo N and grants the first requester found.
// Ports   : req     - request vector
//           ptr     - index holding highest priority this cycle (< N)
//           en      - arbitration enable; 0 forces no grant
//           gnt     - one-hot grant (or zero)
//           gnt_idx - index of the granted requester (0 when none)
//           gnt_vld - a grant was issued
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // One extra bit so ptr+k (< 2N) can be reduced modulo N without overflow,
  // which keeps non-power-of-two N correct.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (en && !gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Shares the common data bus among N_REQ execution units. One
//           completion is granted per cycle in round-robin order and the
//           winner is broadcast from a register one cycle later. A ROB flush
//           suppresses arbitration for that cycle.
// Ports   : clk, rst_n    - clock, asynchronous active-low reset
//           flush         - ROB flush; no grant this cycle
//           exu_req       - per-EXU completion request
//           exu_rdy       - per-EXU grant (combinational, one-hot or zero)
//           exu_tag/wdata/inst_id - packed per-EXU payloads, EXU i at slice i
//           cdb_wr        - broadcast valid
//           cdb_tag/wdata/inst_id - broadcast payload (held when cdb_wr=0)
//           bcast_cnt     - broadcasts issued since reset (wraps)
// Note    : TAG_W and ROB_PTR_W must match the cdb_pkg widths, since the
//           payload register is a cdb_pkt_t.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int ROB_DEPTH = CDB_ROB_DEPTH,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int IDX_W     = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           exu_req,
  output logic [N_REQ-1:0]           exu_rdy,
  input  logic [N_REQ*TAG_W-1:0]     exu_tag,
  input  logic [N_REQ*32-1:0]        exu_wdata,
  input  logic [N_REQ*ROB_PTR_W-1:0] exu_inst_id,
  output logic                       cdb_wr,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [31:0]                cdb_wdata,
  output logic [ROB_PTR_W-1:0]       cdb_inst_id,
  output logic [31:0]                bcast_cnt
);

  cdb_pkt_t         pkts [N_REQ];
  cdb_pkt_t         bcast;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             arb_en;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign pkts[i] = cdb_pkt_t'{
        tag:     exu_tag[i*TAG_W +: TAG_W],
        wdata:   exu_wdata[i*32 +: 32],
        inst_id: exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W]
      };
    end
  endgenerate

  // Gating with rst_n keeps rdy low for the whole reset window, not just
  // after the first edge: an EXU must never see a handshake while in reset.
  assign arb_en = rst_n & ~flush;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (exu_req),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign exu_rdy = gnt;

  // Priority moves to the slot just after the winner.
  assign rr_ptr_nxt = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb_wr    <= 1'b0;
      bcast     <= '0;
      bcast_cnt <= '0;
    end else begin
      cdb_wr <= gnt_vld;
      if (gnt_vld) begin
        rr_ptr    <= rr_ptr_nxt;
        bcast     <= pkts[gnt_idx];
        bcast_cnt <= bcast_cnt + 32'd1;
      end
    end
  end

  assign cdb_tag     = bcast.tag;
  assign cdb_wdata   = bcast.wdata;
  assign cdb_inst_id = bcast.inst_id;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Directed self-checking bench for cdb_arbiter (N_REQ=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  exu_req = '0;
  logic [3:0]  exu_rdy;
  logic [15:0] exu_tag;
  logic [127:0] exu_wdata;
  logic [15:0] exu_inst_id;
  logic        cdb_wr;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic [3:0]  cdb_inst_id;
  logic [31:0] bcast_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0]  tg [N];
  logic [31:0] wd [N];
  logic [3:0]  id [N];

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .ROB_DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .exu_req     (exu_req),
    .exu_rdy     (exu_rdy),
    .exu_tag     (exu_tag),
    .exu_wdata   (exu_wdata),
    .exu_inst_id (exu_inst_id),
    .cdb_wr      (cdb_wr),
    .cdb_tag     (cdb_tag),
    .cdb_wdata   (cdb_wdata),
    .cdb_inst_id (cdb_inst_id),
    .bcast_cnt   (bcast_cnt)
  );

  always #5 clk = ~clk;

  // Default payloads: EXU i has tag 8+i, wdata 0x1000_0000+i, inst_id i+3.
  task automatic load_defaults();
    for (int i = 0; i < N; i++) begin
      tg[i] = 4'(8 + i);
      wd[i] = 32'h1000_0000 + 32'(i);
      id[i] = 4'(i + 3);
    end
    exu_tag     = {tg[3], tg[2], tg[1], tg[0]};
    exu_wdata   = {wd[3], wd[2], wd[1], wd[0]};
    exu_inst_id = {id[3], id[2], id[1], id[0]};
  endtask

  // Returns 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    load_defaults();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cdb_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", cdb_wr); end
    checks++; if (bcast_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bcast_cnt); end
    checks++; if ({cdb_tag, cdb_wdata, cdb_inst_id} !== 40'd0) begin errors++; $display("FAIL rst_payload: got %h/%h/%h want 0", cdb_tag, cdb_wdata, cdb_inst_id); end
    exu_req = 4'b1111;
    #1;
    checks++; if (exu_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy_in_reset: got %b want 0000", exu_rdy); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (exu_rdy !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", exu_rdy); end
    tick();
    checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[0]) begin errors++; $display("FAIL rst_first_bcast: got wr=%b tag=%h want 1/%h", cdb_wr, cdb_tag, tg[0]); end
    tick();
    // Mid-operation asynchronous reset, asserted between edges.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cdb_wr !== 1'b0 || exu_rdy !== 4'b0000) begin errors++; $display("FAIL rst_async: got wr=%b rdy=%b want 0/0000", cdb_wr, exu_rdy); end
    checks++; if (bcast_cnt !== 32'd0) begin errors++; $display("FAIL rst_async_cnt: got %0d want 0", bcast_cnt); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (exu_rdy !== 4'b0001 || bcast_cnt !== 32'd0) begin errors++; $display("FAIL rst_release: got rdy=%b cnt=%0d want 0001/0", exu_rdy, bcast_cnt); end
    exu_req = 4'b0000;
    tick();
  endtask

  // rr_ptr=0, bcast_cnt=0 on entry.
  task automatic test_round_robin();
    logic [3:0] exp;
    exu_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      #1;
      checks++; if (exu_rdy !== exp) begin errors++; $display("FAIL rr_rdy[%0d]: got %b want %b", k, exu_rdy, exp); end
      tick();
      checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[k % 4]) begin errors++; $display("FAIL rr_bcast[%0d]: got wr=%b tag=%h want 1/%h", k, cdb_wr, cdb_tag, tg[k % 4]); end
    end
    exu_req = 4'b0000;
    checks++; if (bcast_cnt !== 32'd8) begin errors++; $display("FAIL rr_cnt: got %0d want 8", bcast_cnt); end
    tick();
    checks++; if (cdb_wr !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", cdb_wr); end
  endtask

  // rr_ptr=0, bcast_cnt=8 on entry; leaves rr_ptr=3, bcast_cnt=11.
  task automatic test_wrap();
    exu_req = 4'b0100;
    #1;
    checks++; if (exu_rdy !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", exu_rdy); end
    tick();
    exu_req = 4'b0101;
    #1;
    checks++; if (exu_rdy !== 4'b0001) begin errors++; $display("FAIL wrap_to_0: got %b want 0001", exu_rdy); end
    tick();
    checks++; if (cdb_tag !== tg[0] || cdb_inst_id !== id[0]) begin errors++; $display("FAIL wrap_bcast: got tag=%h id=%h want %h/%h", cdb_tag, cdb_inst_id, tg[0], id[0]); end
    exu_req = 4'b0100;
    #1;
    checks++; if (exu_rdy !== 4'b0100) begin errors++; $display("FAIL wrap_next: got %b want 0100", exu_rdy); end
    tick();
    exu_req = 4'b0000;
    checks++; if (bcast_cnt !== 32'd11) begin errors++; $display("FAIL wrap_cnt: got %0d want 11", bcast_cnt); end
  endtask

  // rr_ptr=3 on entry; leaves rr_ptr=3, bcast_cnt=12.
  task automatic test_latency();
    exu_tag[8 +: 4]       = 4'hA;
    exu_wdata[64 +: 32]   = 32'hDEADBEEF;
    exu_inst_id[8 +: 4]   = 4'd5;
    exu_req = 4'b0100;
    #1;
    checks++; if (exu_rdy !== 4'b0100) begin errors++; $display("FAIL lat_rdy: got %b want 0100", exu_rdy); end
    tick();
    exu_req = 4'b0000;
    checks++; if (cdb_wr !== 1'b1 || cdb_tag !== 4'hA || cdb_wdata !== 32'hDEADBEEF || cdb_inst_id !== 4'd5) begin errors++; $display("FAIL lat_bcast: got %b/%h/%h/%h want 1/a/deadbeef/5", cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id); end
    tick();
    checks++; if (cdb_wr !== 1'b0 || cdb_tag !== 4'hA) begin errors++; $display("FAIL lat_t2: got wr=%b tag=%h want 0/a", cdb_wr, cdb_tag); end
    load_defaults();
  endtask

  // rr_ptr=3, bcast_cnt=12 on entry; leaves rr_ptr=2, bcast_cnt=14.
  task automatic test_flush();
    exu_req = 4'b0011;
    flush   = 1'b1;
    #1;
    checks++; if (exu_rdy !== 4'b0000) begin errors++; $display("FAIL flush_rdy: got %b want 0000", exu_rdy); end
    tick();
    flush = 1'b0;
    checks++; if (cdb_wr !== 1'b0 || bcast_cnt !== 32'd12) begin errors++; $display("FAIL flush_wr: got wr=%b cnt=%0d want 0/12", cdb_wr, bcast_cnt); end
    #1;
    checks++; if (exu_rdy !== 4'b0001) begin errors++; $display("FAIL flush_resume: got %b want 0001", exu_rdy); end
    tick();
    checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[0]) begin errors++; $display("FAIL flush_bcast0: got wr=%b tag=%h want 1/%h", cdb_wr, cdb_tag, tg[0]); end
    tick();
    // Broadcast of EXU1 is on the bus now; a flush must not retract it.
    flush = 1'b1;
    #1;
    checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[1] || exu_rdy !== 4'b0000) begin errors++; $display("FAIL flush_onbus: got wr=%b tag=%h rdy=%b want 1/%h/0000", cdb_wr, cdb_tag, exu_rdy, tg[1]); end
    tick();
    flush = 1'b0;
    checks++; if (cdb_wr !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", cdb_wr); end
    #1;
    checks++; if (exu_rdy !== 4'b0001) begin errors++; $display("FAIL flush_ptr_hold: got %b want 0001", exu_rdy); end
    exu_req = 4'b0000;
    tick();
  endtask

  // rr_ptr=2, bcast_cnt=14 on entry. EXU1 waits while EXU2 and EXU3 win.
  task automatic test_hold();
    exu_req = 4'b1110;
    #1;
    checks++; if (exu_rdy !== 4'b0100) begin errors++; $display("FAIL hold_c1: got %b want 0100", exu_rdy); end
    tick();
    exu_req = 4'b1010;
    checks++; if (cdb_tag !== tg[2]) begin errors++; $display("FAIL hold_b1: got %h want %h", cdb_tag, tg[2]); end
    #1;
    checks++; if (exu_rdy !== 4'b1000) begin errors++; $display("FAIL hold_c2: got %b want 1000", exu_rdy); end
    tick();
    exu_req = 4'b0010;
    checks++; if (cdb_tag !== tg[3]) begin errors++; $display("FAIL hold_b2: got %h want %h", cdb_tag, tg[3]); end
    #1;
    checks++; if (exu_rdy !== 4'b0010) begin errors++; $display("FAIL hold_c3: got %b want 0010", exu_rdy); end
    tick();
    exu_req = 4'b0000;
    checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[1] || cdb_wdata !== wd[1]) begin errors++; $display("FAIL hold_b3: got wr=%b tag=%h data=%h want 1/%h/%h", cdb_wr, cdb_tag, cdb_wdata, tg[1], wd[1]); end
    tick();
    checks++; if (cdb_wr !== 1'b0 || bcast_cnt !== 32'd17) begin errors++; $display("FAIL hold_once: got wr=%b cnt=%0d want 0/17", cdb_wr, bcast_cnt); end
  endtask

  // rr_ptr=2 on entry: a lone requester wins every cycle regardless of ptr.
  task automatic test_back_to_back();
    exu_req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (exu_rdy !== 4'b0001) begin errors++; $display("FAIL b2b_rdy[%0d]: got %b want 0001", k, exu_rdy); end
      tick();
      checks++; if (cdb_wr !== 1'b1 || cdb_tag !== tg[0]) begin errors++; $display("FAIL b2b_bcast[%0d]: got wr=%b tag=%h want 1/%h", k, cdb_wr, cdb_tag, tg[0]); end
    end
    exu_req = 4'b0000;
    checks++; if (bcast_cnt !== 32'd20) begin errors++; $display("FAIL b2b_cnt: got %0d want 20", bcast_cnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_latency();
    test_flush();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cdb_arbiter
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N_REQ execution units (ALU, MUL/DIV, LSU, BR).
- Each EXU raises a req/rdy completion handshake carrying tag, wdata and inst_id. The arbiter grants one per cycle in round-robin order.
- The winner is registered and broadcast one cycle later to the RFU, reservation stations and ROB.
- A ROB flush kills arbitration and the pending broadcast.

Parameters:
- N_REQ, 4, number of EXU requesters (2..8)
- TAG_W, 4, physical/rename tag width
- ROB_DEPTH, 16, ROB entries
- ROB_PTR_W, $clog2(ROB_DEPTH), inst_id width
- IDX_W, $clog2(N_REQ), requester index width

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  ROB mispredict/exception flush
- exu_req  in  N_REQ  per-EXU completion request
- exu_rdy  out  N_REQ  per-EXU grant; one-hot or zero; combinational
- exu_tag  in  N_REQ*TAG_W  packed tags; EXU i at [i*TAG_W +: TAG_W]
- exu_wdata  in  N_REQ*32  packed result data
- exu_inst_id  in  N_REQ*ROB_PTR_W  packed ROB indices
- cdb_wr  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_wdata  out  32  broadcast data
- cdb_inst_id  out  ROB_PTR_W  broadcast ROB index
- bcast_cnt  out  32  broadcasts issued since reset (perf)

Behaviour:
- Reset (rst_n=0, async): cdb_wr=0, cdb_tag=0, cdb_wdata=0, cdb_inst_id=0, rr_ptr=0, bcast_cnt=0. exu_rdy=0 while in reset.
- Handshake: an EXU holds req with stable tag/wdata/inst_id until it sees rdy=1 in the same cycle. A transfer occurs when req&rdy. rdy never asserts without req.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - The first index with req=1 wins and gets exu_rdy=1; all other rdy bits are 0.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds. Wrap: g=N_REQ-1 gives rr_ptr=0.
- Latency: a grant in cycle t gives cdb_wr=1 with the winner's tag/wdata/inst_id in cycle t+1. Max throughput is 1 broadcast/cycle. Back-to-back grants to different EXUs are allowed.
- No grant in cycle t: cdb_wr=0 in t+1. tag/wdata/inst_id hold their last values (don't-care when wr=0).
- bcast_cnt increments by 1 in every cycle a grant is registered. It wraps at 2^32.
- Flush:
  - In a flush=1 cycle, exu_rdy=0 for all EXUs and rr_ptr holds.
  - cdb_wr=0 in the next cycle.
  - A broadcast already on the bus during the flush cycle is not retracted; consumers discard it.
  - Requesters still asserting req after the flush are arbitrated normally; EXUs drop their own req on flush.
- Starvation bound: a continuously requesting EXU is granted within N_REQ non-flush cycles.
- Single requester: granted every cycle it requests, regardless of rr_ptr.
- All requesters active: grant order is rr_ptr, rr_ptr+1, ... strictly rotating.

Decomposition:
- Package cdb_pkg:
  - TAG_W and ROB_PTR_W defaults.
  - Struct cdb_pkt_t {tag, wdata, inst_id} used for the output register and the unpacked input array.
- Sub-module rr_arbiter (params N, IDX_W):
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot gnt, gnt_idx, gnt_vld.
  - Pure combinational priority rotate. Reused later for RVS issue select.
- cdb_arbiter owns rr_ptr, the output register, bcast_cnt and flush gating.

Test Plan:
- Reset mid-operation: drive exu_req=4'b1111, assert rst_n=0 between edges -> cdb_wr=0, exu_rdy=0 immediately. After release, first grant goes to EXU0 and bcast_cnt=0.
- Round-robin with N_REQ=4, all req held high for 8 cycles -> exu_rdy sequence 0001,0010,0100,1000,0001,... and cdb_tag follows the winners' tags one cycle later. bcast_cnt=8.
- Pointer wrap: rr_ptr=3, req=4'b0101 -> EXU0 granted (3 idle, wrap to 0). Next cycle with req=4'b0100 -> EXU2 granted.
- Latency/data: EXU2 req with tag=4'hA, wdata=32'hDEADBEEF, inst_id=5 at cycle t -> cycle t+1 shows cdb_wr=1, tag=A, wdata=DEADBEEF, inst_id=5. Cycle t+2 shows cdb_wr=0 if there is no new req.
- Flush: req=4'b0011 with flush=1 at t -> exu_rdy=0 at t, cdb_wr=0 at t+1, rr_ptr unchanged. flush=0 at t+1 -> grant resumes at the pre-flush pointer.
- Hold rule: EXU1 holds req for 3 cycles while others win -> its data is broadcast exactly once, after its rdy.
